// File: rtl/core_mem_arbiter_pkg.sv
// core_mem_arbiter_pkg: shared memory-bus widths and arbiter FSM state encoding.
package core_mem_arbiter_pkg;
   localparam int MEM_ADDR_R = 31;
   localparam int MEM_DATA_R = 31;
   localparam int MEM_STRB_R = 3;
   typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} state_t;
endpackage

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: two-requester (fetch/data) arbiter onto one shared memory port.
// Define CORE_MEM_ARB_RR_EN for round-robin on simultaneous requests; default is fixed dmem priority.
module core_mem_arbiter
   import core_mem_arbiter_pkg::*;
(
   input  logic                  g_clk,
   input  logic                  g_resetn,
   input  logic                  imem_req,
   input  logic [MEM_ADDR_R:0]   imem_addr,
   output logic                  imem_gnt,
   output logic                  imem_err,
   output logic [MEM_DATA_R:0]   imem_rdata,
   input  logic                  dmem_req,
   input  logic [MEM_ADDR_R:0]   dmem_addr,
   input  logic                  dmem_wen,
   input  logic [MEM_STRB_R:0]   dmem_strb,
   input  logic [MEM_DATA_R:0]   dmem_wdata,
   output logic                  dmem_gnt,
   output logic                  dmem_err,
   output logic [MEM_DATA_R:0]   dmem_rdata,
   output logic                  mem_req,
   output logic [MEM_ADDR_R:0]   mem_addr,
   output logic                  mem_wen,
   output logic [MEM_STRB_R:0]   mem_strb,
   output logic [MEM_DATA_R:0]   mem_wdata,
   input  logic                  mem_gnt,
   input  logic                  mem_err,
   input  logic [MEM_DATA_R:0]   mem_rdata
);
   state_t state_q, state_d;
   logic   win_d, fwd_i, fwd_d;
`ifdef CORE_MEM_ARB_RR_EN
   logic   last_dmem_q;
   assign win_d = dmem_req & (~imem_req | ~last_dmem_q);
   always_ff @(posedge g_clk or negedge g_resetn)
      if (!g_resetn) last_dmem_q <= 1'b0;
      else if (mem_req & mem_gnt) last_dmem_q <= fwd_d;
`else
   assign win_d = dmem_req;
`endif
   // Reset gates forwarding combinationally so mem_req drops the instant reset asserts.
   always_comb begin
      fwd_i   = g_resetn & ((state_q == OWN_I) ? imem_req : ((state_q == IDLE) & imem_req & ~win_d));
      fwd_d   = g_resetn & ((state_q == OWN_D) ? dmem_req : ((state_q == IDLE) & win_d));
      state_d = (mem_gnt | ~(fwd_i | fwd_d)) ? IDLE : fwd_d ? OWN_D : OWN_I;
   end
   always_ff @(posedge g_clk or negedge g_resetn)
      if (!g_resetn) state_q <= IDLE;
      else state_q <= state_d;
   assign mem_req    = fwd_i | fwd_d;
   assign mem_addr   = fwd_d ? dmem_addr : fwd_i ? imem_addr : '0;
   assign mem_wen    = fwd_d & dmem_wen;
   assign mem_strb   = fwd_d ? dmem_strb : {(MEM_STRB_R + 1){fwd_i}};
   assign mem_wdata  = fwd_d ? dmem_wdata : '0;
   assign imem_gnt   = fwd_i & mem_gnt;
   assign dmem_gnt   = fwd_d & mem_gnt;
   assign imem_err   = imem_gnt & mem_err;
   assign dmem_err   = dmem_gnt & mem_err;
   assign imem_rdata = imem_gnt ? mem_rdata : '0;
   assign dmem_rdata = dmem_gnt ? mem_rdata : '0;
endmodule
